seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display in the Caravel user project area. It holds DIGITS 4-bit digit codes and cycles a one-hot digit enable through them at a programmable dwell. A blanking gap between digits prevents ghosting. New digit values enter through a valid/ready handshake and are applied atomically at frame boundaries. Its segment output uses the same 7-bit encoding as the existing seconds counter on mprj_io[14:8], and its digit enables go to adjacent mprj_io pins.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- DIV_W, 16, width of the dwell count
- wb_clk_i  in  1  clock; single clock domain
- wb_rst_i  in  1  reset, synchronous, active-high
- enable  in  1  scan enable
- dwell  in  DIV_W  SHOW length per digit in cycles; 0 treated as 1
- blank  in  8  BLANK length between digits in cycles; 0 = no BLANK phase
- lz_suppress  in  1  leading-zero suppression enable
- load_valid  in  1  new digit set offered
- load_data  in  4*DIGITS  digit codes, digit i at [4i+3:4i]; digit DIGITS-1 most significant
- load_ready  out  1  pending slot empty
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- dig_en  out  DIGITS  one-hot digit enable, active-high
- digit_idx  out  clog2(DIGITS)  index of current/next digit
- frame_done  out  1  one-cycle pulse per completed frame

## Operation
- Registers:
  - active: DIGITS×4, drives the display.
  - pending: DIGITS×4, plus a pending_valid flag.
  - FSM: IDLE, SHOW, BLANK.
  - phase counter, DIV_W bits.
  - digit index.
- Handshake:
  - load_ready = !pending_valid.
  - On load_valid && load_ready, load_data is latched into pending and pending_valid is set.
  - load_data is ignored when load_ready is low.
- Copy of pending to active:
  - Happens on any cycle the FSM is in IDLE with pending_valid set, or at a frame boundary with pending_valid already set.
  - The copy clears pending_valid.
  - A load accepted in the boundary cycle itself is applied at the next boundary.
- FSM:
  - IDLE → SHOW(digit 0) when enable=1.
  - SHOW → BLANK after max(dwell,1) cycles if blank≠0; otherwise SHOW → SHOW(next digit).
  - BLANK → SHOW(next digit) after blank cycles.
  - Frame boundary = leaving the last digit's final phase. Index wraps DIGITS-1 → 0 and frame_done pulses.
  - enable=0 in any state → IDLE on the next edge. The partial frame is abandoned, with no frame_done.
- SHOW outputs: dig_en = 1<<digit_idx; seg = decode(active[digit_idx]).
- BLANK and IDLE outputs: dig_en=0, seg=0.
- Decode table:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111
  - 10=1000000 (dash), 11..15=0000000 (blank)
- Leading-zero suppression: when lz_suppress=1, digit i≠0 shows seg=0 if it and all higher digits are 0. dig_en still asserts. Digit 0 is never suppressed.
- dwell and blank are sampled when each phase is entered; changes take effect at the next phase.

## Timing
- Reset values (next edge after wb_rst_i=1):
  - outputs: seg=0, dig_en=0, digit_idx=0, frame_done=0, load_ready=1
  - internal: active=0, pending discarded, FSM=IDLE
- Reset mid-frame or mid-handshake: same reset values; nothing is retained.
- seg and dig_en are registered and change on the same edge as the FSM state. They never show one digit's enable with another digit's segments.
- Edge after enable rises in IDLE: SHOW digit 0 visible.
- Frame period = DIGITS × (max(dwell,1) + blank) cycles.
- frame_done is high for exactly the first cycle of the next frame's digit-0 SHOW. If enable fell, that cycle is IDLE and no frame_done is issued.
- Load latency:
  - In IDLE, accepted data reaches active 1 cycle after acceptance.
  - While scanning, data reaches active at the first frame boundary strictly after acceptance.
  - load_ready returns high the cycle after the copy.
- load_valid held with load_ready low: no acceptance and no state change.

## Test plan
- Reset and idle:
  - Stimulus: assert wb_rst_i mid-SHOW with pending_valid set.
  - Response: next cycle seg=0, dig_en=0, load_ready=1; after re-enable, digit 0 shows 0111111.
- Basic scan:
  - Stimulus: DIGITS=4, dwell=3, blank=1, load 0x4321, enable.
  - Response: dig_en 0001/0010/0100/1000, each high 3 cycles with a 1-cycle gap of all zeros.
  - Required seg per digit: 0000110, 1011011, 1001111, 1100110.
  - frame_done period is 16 cycles.
- Decode sweep:
  - Stimulus: load each value 0..15 into digit 0.
  - Response: seg matches the decode table, including 6=1111100, 9=1100111, 10=1000000, and 0000000 for 11..15.
- Atomic update:
  - Stimulus: load 0x1111 mid-frame, then offer 0x2222 while load_ready=0.
  - Response: the 0x1111 load is accepted immediately, with the 0x2222 offer held off.
  - 0x1111 appears only on the frame after the boundary; no mixed frame.
  - 0x2222 is accepted the cycle after the copy.
- Boundary collision and leading zeros:
  - Stimulus: accept a load in the exact boundary cycle.
  - Response: it is applied one frame later.
  - Stimulus: lz_suppress=1 with value 0x0070.
  - Response: digits 3 and 2 seg=0; digit 1=0000111; digit 0=0111111.
- Edge parameters:
  - Stimulus: dwell=0, blank=0.
  - Response: each digit shows 1 cycle, no gap, frame=4 cycles.
  - Stimulus: drop enable mid-frame.
  - Response: IDLE next cycle with outputs 0 and no frame_done.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with optional inter-digit blanking
// and a double-buffered digit set that is swapped only at frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16,
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      dwell,
    input  logic [7:0]            blank,
    input  logic                  lz_suppress,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic                  load_ready,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam int CNT_W = (DIV_W > 8) ? DIV_W : 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     dig_en_q, dig_en_d;
    logic                  frame_done_q, frame_done_d;

    logic [CNT_W-1:0]      show_len_m1;
    logic [CNT_W-1:0]      blank_len_m1;
    logic                  advance;
    logic                  boundary;
    logic [3:0]            cur_code;
    logic                  higher_zero;
    logic                  suppress;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111100;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1100111;
            4'd10:   s = 7'b1000000;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Phase counters hold "cycles remaining minus one", so a zero dwell behaves as one.
    assign show_len_m1  = (dwell == '0) ? '0 : CNT_W'(dwell) - 1'b1;
    assign blank_len_m1 = CNT_W'(blank) - 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        advance  = 1'b0;
        boundary = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    cnt_d   = show_len_m1;
                    idx_d   = '0;
                end
                ST_SHOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (blank != 8'd0) begin
                        state_d = ST_BLANK;
                        cnt_d   = blank_len_m1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
            if (advance) begin
                state_d = ST_SHOW;
                cnt_d   = show_len_m1;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    boundary = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    // Copy and accept are mutually exclusive: copy needs a full slot, accept an empty one.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (pending_valid_q && ((state_q == ST_IDLE) || boundary)) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end else if (load_valid && !pending_valid_q) begin
            pending_d       = load_data;
            pending_valid_d = 1'b1;
        end
    end

    // Outputs are derived from next-state values so enables and segments always agree.
    always_comb begin
        cur_code    = 4'd0;
        higher_zero = 1'b1;
        suppress    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (IDX_W'(i) == idx_d) begin
                cur_code = active_d[4*i +: 4];
                suppress = lz_suppress && (i != 0) && higher_zero
                           && (active_d[4*i +: 4] == 4'd0);
            end
            higher_zero = higher_zero && (active_d[4*i +: 4] == 4'd0);
        end
        seg_d        = 7'd0;
        dig_en_d     = '0;
        frame_done_d = boundary;
        if (state_d == ST_SHOW) begin
            dig_en_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
            seg_d    = suppress ? 7'd0 : decode(cur_code);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            seg_q           <= 7'd0;
            dig_en_q        <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            dig_en_q        <= dig_en_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign load_ready = !pending_valid_q;
    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: directed scenarios plus randomized
// traffic, compared every cycle against a schedule-based reference model.
module tb_seven_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV_W  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] dwell = 16'd3;
    logic [7:0]  blank = 8'd1;
    logic        lz = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_ctrl #(.DIGITS(DIGITS), .DIV_W(DIV_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .enable     (enable),
        .dwell      (dwell),
        .blank      (blank),
        .lz_suppress(lz),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .seg        (seg),
        .dig_en     (dig_en),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_table [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                   7'b1100110, 7'b1101101, 7'b1111100, 7'b0000111,
                                   7'b1111111, 7'b1100111, 7'b1000000, 7'b0000000,
                                   7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the scan is a fixed schedule measured from the enabling edge.
    bit          m_valid = 0;
    bit          m_scan = 0;
    bit          m_pend_v = 0;
    int          m_t = 0;
    int          m_len = 1;
    int          m_blk = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic [6:0]  m_exp_seg = 7'd0;
    logic [3:0]  m_exp_dig = 4'd0;
    int          m_exp_idx = 0;
    bit          m_chk_idx = 1;
    bit          m_exp_fd = 0;
    bit          m_exp_ready = 1;

    function automatic logic [6:0] modelSeg(input logic [15:0] act, input int d, input logic lzs);
        bit all_zero = 1;
        for (int j = d; j < DIGITS; j++)
            if (act[4*j +: 4] != 4'd0) all_zero = 0;
        if (lzs && d != 0 && all_zero) return 7'd0;
        return seg_table[act[4*d +: 4]];
    endfunction

    always @(posedge clk) begin : model_step
        bit accept;
        int per, frame, pos, d;
        if (rst) begin
            m_valid  = 1;
            m_scan   = 0;
            m_active = 16'h0;
            m_pend   = 16'h0;
            m_pend_v = 0;
        end else if (m_valid) begin
            accept = load_valid && !m_pend_v;
            if (!m_scan) begin
                if (m_pend_v) begin
                    m_active = m_pend;
                    m_pend_v = 0;
                end
                if (enable) begin
                    m_scan = 1;
                    m_t    = 0;
                    m_len  = (dwell == 16'd0) ? 1 : int'(dwell);
                    m_blk  = int'(blank);
                end
            end else if (!enable) begin
                m_scan = 0;
            end else begin
                m_t++;
                if ((m_t % (DIGITS * (m_len + m_blk))) == 0 && m_pend_v) begin
                    m_active = m_pend;
                    m_pend_v = 0;
                end
            end
            if (accept) begin
                m_pend   = load_data;
                m_pend_v = 1;
            end
        end
        if (m_scan) begin
            per   = m_len + m_blk;
            frame = DIGITS * per;
            pos   = m_t % frame;
            d     = pos / per;
            if ((pos % per) < m_len) begin
                m_exp_dig = 4'(1 << d);
                m_exp_seg = modelSeg(m_active, d, lz);
                m_exp_idx = d;
                m_chk_idx = 1;
            end else begin
                m_exp_dig = 4'd0;
                m_exp_seg = 7'd0;
                m_chk_idx = 0;
            end
            m_exp_fd = (m_t > 0) && (pos == 0);
        end else begin
            m_exp_dig = 4'd0;
            m_exp_seg = 7'd0;
            m_exp_idx = 0;
            m_chk_idx = 1;
            m_exp_fd  = 0;
        end
        m_exp_ready = !m_pend_v;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_seg", 32'(seg), 32'(m_exp_seg));
            checkOutput("model_dig_en", 32'(dig_en), 32'(m_exp_dig));
            checkOutput("model_frame_done", 32'(frame_done), 32'(m_exp_fd));
            checkOutput("model_load_ready", 32'(load_ready), 32'(m_exp_ready));
            if (m_chk_idx) checkOutput("model_digit_idx", 32'(digit_idx), 32'(m_exp_idx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic lv, input logic [15:0] ld);
        enable     = en;
        load_valid = lv;
        load_data  = ld;
        tick();
    endtask

    function automatic logic [15:0] randDigits();
        logic [15:0] v;
        for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        int fd_first, fd_second, n_cyc;
        bit got;

        tick();
        tick();
        $display("[TB] reset checks");
        checkOutput("reset_seg", 32'(seg), 32'd0);
        checkOutput("reset_dig_en", 32'(dig_en), 32'd0);
        checkOutput("reset_idx", 32'(digit_idx), 32'd0);
        checkOutput("reset_fd", 32'(frame_done), 32'd0);
        checkOutput("reset_ready", 32'(load_ready), 32'd1);
        rst = 1'b0;

        $display("[TB] basic scan 0x4321 dwell=3 blank=1");
        applyStimulus(1'b0, 1'b1, 16'h4321);
        checkOutput("basic_accept_ready", 32'(load_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("basic_k0_dig", 32'(dig_en), 32'b0001);
        checkOutput("basic_k0_seg", 32'(seg), 32'b0000110);
        fd_first  = -1;
        fd_second = -1;
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b1, 1'b0, 16'h0);
            if (frame_done) begin
                if (fd_first < 0) fd_first = k;
                else if (fd_second < 0) fd_second = k;
            end
            case (k)
                1:  checkOutput("basic_k1_fd", 32'(frame_done), 32'd0);
                3:  begin
                        checkOutput("basic_gap_dig", 32'(dig_en), 32'd0);
                        checkOutput("basic_gap_seg", 32'(seg), 32'd0);
                    end
                4:  begin
                        checkOutput("basic_d1_dig", 32'(dig_en), 32'b0010);
                        checkOutput("basic_d1_seg", 32'(seg), 32'b1011011);
                    end
                8:  begin
                        checkOutput("basic_d2_dig", 32'(dig_en), 32'b0100);
                        checkOutput("basic_d2_seg", 32'(seg), 32'b1001111);
                    end
                12: begin
                        checkOutput("basic_d3_dig", 32'(dig_en), 32'b1000);
                        checkOutput("basic_d3_seg", 32'(seg), 32'b1100110);
                    end
                16: checkOutput("basic_k16_fd", 32'(frame_done), 32'd1);
                default: ;
            endcase
        end
        checkOutput("basic_frame_period", 32'(fd_second - fd_first), 32'd16);

        $display("[TB] reset mid-show with pending load");
        applyStimulus(1'b1, 1'b1, 16'h9999);
        checkOutput("rstmid_pending_ready", 32'(load_ready), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0);
        rst = 1'b0;
        checkOutput("rstmid_seg", 32'(seg), 32'd0);
        checkOutput("rstmid_dig_en", 32'(dig_en), 32'd0);
        checkOutput("rstmid_ready", 32'(load_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("rstmid_reen_dig", 32'(dig_en), 32'b0001);
        checkOutput("rstmid_reen_seg", 32'(seg), 32'b0111111);

        $display("[TB] decode sweep");
        for (int v = 0; v < 16; v++) begin
            applyStimulus(1'b0, 1'b0, 16'h0);
            applyStimulus(1'b0, 1'b1, 16'(v));
            applyStimulus(1'b1, 1'b0, 16'h0);
            checkOutput($sformatf("decode_%0d", v), 32'(seg), 32'(seg_table[v]));
        end

        $display("[TB] atomic update");
        applyStimulus(1'b0, 1'b0, 16'h0);
        dwell = 16'd2;
        blank = 8'd1;
        applyStimulus(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 16'h1111);
        checkOutput("atomic_1111_accepted", 32'(load_ready), 32'd0);
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            applyStimulus(1'b1, 1'b1, 16'h2222);
            if (load_ready) got = 1;
        end
        checkOutput("atomic_copy_seen", 32'(got), 32'd1);
        checkOutput("atomic_copy_fd", 32'(frame_done), 32'd1);
        checkOutput("atomic_copy_seg", 32'(seg), 32'b0000110);
        applyStimulus(1'b1, 1'b1, 16'h2222);
        checkOutput("atomic_2222_accepted", 32'(load_ready), 32'd0);
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            applyStimulus(1'b1, 1'b0, 16'h0);
            if (load_ready) got = 1;
        end
        checkOutput("atomic_second_copy_seen", 32'(got), 32'd1);
        checkOutput("atomic_second_seg", 32'(seg), 32'b1011011);

        $display("[TB] load accepted in boundary cycle");
        for (int k = 0; k < 11; k++) applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 16'h5555);
        checkOutput("collide_fd", 32'(frame_done), 32'd1);
        checkOutput("collide_ready", 32'(load_ready), 32'd0);
        checkOutput("collide_old_seg", 32'(seg), 32'b1011011);
        for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("collide_next_fd", 32'(frame_done), 32'd1);
        checkOutput("collide_new_seg", 32'(seg), 32'b1101101);
        checkOutput("collide_next_ready", 32'(load_ready), 32'd1);

        $display("[TB] leading-zero suppression 0x0070");
        applyStimulus(1'b0, 1'b0, 16'h0);
        lz    = 1'b1;
        dwell = 16'd1;
        blank = 8'd0;
        applyStimulus(1'b0, 1'b1, 16'h0070);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("lz_d0_seg", 32'(seg), 32'b0111111);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("lz_d1_seg", 32'(seg), 32'b0000111);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("lz_d2_dig", 32'(dig_en), 32'b0100);
        checkOutput("lz_d2_seg", 32'(seg), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("lz_d3_dig", 32'(dig_en), 32'b1000);
        checkOutput("lz_d3_seg", 32'(seg), 32'd0);

        $display("[TB] dwell=0 blank=0");
        applyStimulus(1'b0, 1'b0, 16'h0);
        lz    = 1'b0;
        dwell = 16'd0;
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("fast_t0_dig", 32'(dig_en), 32'b0001);
        fd_first  = -1;
        fd_second = -1;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, 16'h0);
            if (frame_done) begin
                if (fd_first < 0) fd_first = k;
                else if (fd_second < 0) fd_second = k;
            end
            if (k == 1) checkOutput("fast_t1_dig", 32'(dig_en), 32'b0010);
            if (k == 3) checkOutput("fast_t3_dig", 32'(dig_en), 32'b1000);
        end
        checkOutput("fast_frame_period", 32'(fd_second - fd_first), 32'd4);

        $display("[TB] drop enable mid-frame");
        applyStimulus(1'b0, 1'b0, 16'h0);
        dwell = 16'd3;
        blank = 8'd1;
        applyStimulus(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("drop_seg", 32'(seg), 32'd0);
        checkOutput("drop_dig_en", 32'(dig_en), 32'd0);
        checkOutput("drop_fd", 32'(frame_done), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("drop_restart_dig", 32'(dig_en), 32'b0001);

        $display("[TB] randomized traffic");
        for (int s = 0; s < 25; s++) begin
            applyStimulus(1'b0, 1'b0, 16'h0);
            dwell = 16'($urandom_range(0, 4));
            blank = 8'($urandom_range(0, 3));
            lz    = 1'($urandom_range(0, 1));
            n_cyc = $urandom_range(5, 60);
            for (int k = 0; k < n_cyc; k++) begin
                rst = ($urandom_range(0, 59) == 0);
                applyStimulus(1'b1, ($urandom_range(0, 3) == 0), randDigits());
                rst = 1'b0;
            end
        end
        applyStimulus(1'b0, 1'b0, 16'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
